// File: rtl/fib_engine.sv
// Fibonacci engine: requests queue in a DEPTH-entry FIFO; fib(n) is computed one add per cycle, result after n+2 cycles when idle.
// A stalled result holds the engine in DONE; the FIFO keeps accepting until full, then param ack drops.
module fib_engine #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 4,
  parameter int SATURATE = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [WIDTH-1:0]                 channel_param_data,
  input  logic                             channel_param_en,
  output logic                             channel_param_ack,
  output logic [WIDTH-1:0]                 channel_result_data,
  output logic                             channel_result_overflow,
  output logic                             channel_result_en,
  input  logic                             channel_result_ack,
  output logic [$clog2(DEPTH+1)-1:0]       status_pending
);

  localparam int PW     = $clog2(DEPTH);
  localparam int CW     = $clog2(DEPTH+1);
  localparam bit SAT_EN = (SATURATE != 0);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] fifo_mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] a_q, b_q, cnt_q, data_q;
  logic             a_ovf_q, b_ovf_q, ovf_q, res_en_q;
  logic             push, pop;
  logic [WIDTH:0]   sum_d;

  assign channel_param_ack       = !rst && (count_q != CW'(DEPTH));
  assign push                    = channel_param_en && channel_param_ack;
  assign pop                     = (state_q == IDLE) && (count_q != '0);
  assign sum_d                   = {1'b0, a_q} + {1'b0, b_q};
  assign channel_result_data     = data_q;
  assign channel_result_overflow = ovf_q;
  assign channel_result_en       = res_en_q;
  assign status_pending          = count_q;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= channel_param_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // a_ovf trails b_ovf by one step, so it marks the point where fib(j) itself no longer fits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      a_ovf_q  <= 1'b0;
      b_ovf_q  <= 1'b0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
      res_en_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            a_q     <= '0;
            b_q     <= WIDTH'(1);
            cnt_q   <= fifo_mem[rd_ptr_q];
            a_ovf_q <= 1'b0;
            b_ovf_q <= 1'b0;
            state_q <= CALC;
          end
        end
        CALC: begin
          if (cnt_q == '0 || (SAT_EN && a_ovf_q)) begin
            data_q   <= (SAT_EN && a_ovf_q) ? '1 : a_q;
            ovf_q    <= a_ovf_q;
            res_en_q <= 1'b1;
            state_q  <= DONE;
          end else begin
            a_q     <= b_q;
            b_q     <= sum_d[WIDTH-1:0];
            b_ovf_q <= b_ovf_q | sum_d[WIDTH];
            a_ovf_q <= b_ovf_q;
            cnt_q   <= cnt_q - WIDTH'(1);
          end
        end
        DONE: begin
          if (channel_result_ack) begin
            res_en_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fib_engine.md
# fib_engine

Parametrised Fibonacci compute engine, the next generation of the single-request `fib` block. It takes a request n over the param channel into a `DEPTH`-entry request FIFO and computes fib(n) iteratively, one addition per cycle. It returns the result with an overflow flag over the result channel. Width is configurable, and on overflow the engine either saturates with early exit or wraps modulo 2^WIDTH.

## Interface
Parameters:
- `WIDTH`, 32: width of n and of the result.
- `DEPTH`, 4: request FIFO entries; power of two, ≥ 2.
- `SATURATE`, 1: 1 = on overflow, return all-ones and exit early; 0 = return the value modulo 2^WIDTH and run all n steps.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `channel_param_data`  in  WIDTH  request n.
- `channel_param_en`  in  1  request valid.
- `channel_param_ack`  out  1  engine can accept a request.
- `channel_result_data`  out  WIDTH  fib(n), saturated or wrapped.
- `channel_result_overflow`  out  1  true fib(n) ≥ 2^WIDTH.
- `channel_result_en`  out  1  result valid.
- `channel_result_ack`  in  1  consumer ready.
- `status_pending`  out  clog2(DEPTH+1)  requests queued in the FIFO, excluding the one in flight.

## Operation
- **Handshake.** A transfer happens on a rising edge where en and ack are both 1. Either side may raise its signal first and hold it. The initiator holds data stable while en=1 and no transfer has occurred.
- **Param acceptance.** `channel_param_ack` = !rst && FIFO not full (combinational from the registered count). An en without ack is ignored; nothing is lost and nothing is written.
- **Datapath registers.**
  - `a`, `b` (WIDTH bits): running Fibonacci pair.
  - `cnt` (WIDTH bits): steps remaining.
  - `a_ovf`, `b_ovf`: sticky overflow flags.
  - Output register for data and overflow.
- **State `IDLE`.** If the FIFO is non-empty, pop the head and load a=0, b=1, cnt=n, a_ovf=b_ovf=0, then go to `CALC`.
- **State `CALC`, exit condition.** If cnt==0, or (SATURATE && a_ovf):
  - capture data = (a_ovf && SATURATE) ? all-ones : a;
  - capture overflow = a_ovf;
  - go to `DONE`.
- **State `CALC`, step.** Otherwise, in one edge:
  - a ← b; b ← a+b (mod 2^WIDTH);
  - b_ovf ← b_ovf | carry-out(a+b); a_ovf ← b_ovf;
  - cnt ← cnt−1.
- **State `DONE`.** `channel_result_en`=1. On result transfer, go to `IDLE`. Data and overflow are held until the transfer.
- **Invariant after step j:** a=fib(j), b=fib(j+1) (mod 2^WIDTH).
- **Enqueue during compute.** The FIFO accepts new requests in every state. Push and pop in the same edge leave the count unchanged. A push while full cannot occur (ack=0).
- **Ordering.** Results are returned strictly in request order.

## Timing
- **Reset.** While `rst`=1 at an edge:
  - FIFO cleared, state=`IDLE`, a=b=cnt=0, flags=0;
  - `channel_result_en`=0, `channel_result_data`=0, `channel_result_overflow`=0;
  - `status_pending`=0, `channel_param_ack`=0.
  - Reset mid-compute or mid-DONE discards all queued and in-flight requests; no result is emitted.
- **Latency.** Param transfer at edge E0, with the engine idle and the FIFO empty:
  - pop at E0+1;
  - `channel_result_en` rises after edge E0+n+2; n=0 → E0+2.
  - With SATURATE=1, latency is capped once overflow is detected (WIDTH=32 → after E0+50 at most).
- **Throughput.** One result per n+3 cycles with the consumer always ready, because `DONE`→`IDLE` costs one bubble.
- **Result backpressure.** A stalled result blocks further compute. The FIFO keeps accepting until it holds DEPTH entries, so DEPTH+1 requests can be outstanding in total.
- **Status.** `status_pending` updates on the edge after a push or pop.

## Test plan
- **Basic sequence.** After reset (10 cycles), n=0..6 one at a time → results 0,1,1,2,3,5,8, overflow=0, latency n+2 cycles each.
- **Width boundary (WIDTH=32).**
  - n=47 → 2971215073, overflow=0.
  - n=48, SATURATE=1 → 0xFFFFFFFF, overflow=1.
  - n=48, SATURATE=0 → 512559680, overflow=1.
- **Early exit.** SATURATE=1, n=0xFFFFFFFF → all-ones, overflow=1, `channel_result_en` high within 50 cycles of acceptance.
- **Backpressure.** DEPTH=4, `channel_result_ack`=0, push n=10,11,12,13,14,15:
  - 5 accepted, then `channel_param_ack`=0 and `status_pending`=4;
  - raising ack drains results 55,89,144,233,377, then 610 for the 6th request once accepted.
- **Simultaneous push/pop.** Push lands on the pop edge with the FIFO holding 1 entry → `status_pending` stays 1; order preserved.
- **Reset mid-operation.** Assert `rst` for 1 cycle during `CALC` of n=40 with 2 queued → all outputs at reset values; no stale result. Next request n=5 → 5.
